// File: rtl/butterfly_general.sv
// Radix-2 DIF single-path delay-feedback butterfly: buffers the first half of a
// frame, emits scaled sums during the second half, then streams out the stored differences.
module butterfly_general #(
    parameter int layer = 12,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             data_in_start,
    input  logic             data_in_end,
    input  logic [WIDTH-1:0] A_real,
    input  logic [WIDTH-1:0] A_img,
    output logic             next_level_start,
    output logic [WIDTH-1:0] D_real,
    output logic [WIDTH-1:0] D_img,
    output logic             data_out_first,
    output logic             data_out_last,
    output logic             rotator_valid
);
    localparam int N  = 1 << layer;
    localparam int M  = N / 2;
    localparam int AW = (layer > 1) ? layer - 1 : 1;

    localparam logic [layer-1:0] IDX_ONE  = layer'(1);
    localparam logic [layer-1:0] IDX_HALF = layer'(M - 1);
    localparam logic [layer-1:0] IDX_LAST = layer'(N - 1);
    localparam logic [AW-1:0]    SLOT_MSK = AW'(M - 1);

    logic             run_q, run_d, flush_q, flush_d, pend_q, pend_d, btb_q, btb_d;
    logic [layer-1:0] cnt_q, cnt_d;

    logic             start_ok, in_run, phase_b, rd_diff, active, we;
    logic [layer-1:0] idx;
    logic [AW-1:0]    slot, rd_addr;

    logic [2*WIDTH-1:0] mem [M];
    logic [2*WIDTH-1:0] rd_q, byp_data_q, mem_rd, wdata;
    logic               byp_q;

    logic [WIDTH-1:0] d_r, d_i;
    logic [WIDTH:0]   sum_r, sum_i, dif_r, dif_i;

    logic [WIDTH-1:0] d_real_q, d_real_d, d_img_q, d_img_d;
    logic             first_q, first_d, last_q, last_d, nls_q, nls_d, rot_q, rot_d;

    // A new frame may start from idle, or exactly one cycle after a frame whose
    // last sample carried data_in_end; its Phase A then drains the pending differences.
    always_comb begin
        start_ok = data_in_start && !run_q && (!flush_q || btb_q);
        in_run   = run_q || start_ok;
        idx      = start_ok ? '0 : cnt_q;
        phase_b  = in_run && (idx > IDX_HALF);
        slot     = idx[AW-1:0] & SLOT_MSK;
        rd_diff  = pend_q && (flush_q || (in_run && !phase_b));
        active   = in_run || flush_q;
        rd_addr  = active ? ((slot + AW'(1)) & SLOT_MSK) : '0;
        we       = in_run;
        mem_rd   = byp_q ? byp_data_q : rd_q;
        d_r      = mem_rd[2*WIDTH-1:WIDTH];
        d_i      = mem_rd[WIDTH-1:0];
        sum_r    = {d_r[WIDTH-1], d_r} + {A_real[WIDTH-1], A_real};
        sum_i    = {d_i[WIDTH-1], d_i} + {A_img[WIDTH-1], A_img};
        dif_r    = {d_r[WIDTH-1], d_r} - {A_real[WIDTH-1], A_real};
        dif_i    = {d_i[WIDTH-1], d_i} - {A_img[WIDTH-1], A_img};
        wdata    = phase_b ? {dif_r[WIDTH:1], dif_i[WIDTH:1]} : {A_real, A_img};
    end

    always_comb begin
        run_d   = run_q;
        flush_d = flush_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        btb_d   = 1'b0;
        if (in_run) begin
            flush_d = 1'b0;
            if (idx == IDX_LAST) begin
                run_d   = 1'b0;
                flush_d = 1'b1;
                cnt_d   = '0;
                pend_d  = 1'b1;
                btb_d   = data_in_end;
            end else begin
                run_d = 1'b1;
                cnt_d = idx + IDX_ONE;
                if (idx == IDX_HALF) pend_d = 1'b0;
            end
        end else if (flush_q) begin
            if (cnt_q == IDX_HALF) begin
                flush_d = 1'b0;
                pend_d  = 1'b0;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + IDX_ONE;
            end
        end
    end

    always_comb begin
        d_real_d = '0;
        d_img_d  = '0;
        if (phase_b) begin
            d_real_d = sum_r[WIDTH:1];
            d_img_d  = sum_i[WIDTH:1];
        end else if (rd_diff) begin
            d_real_d = d_r;
            d_img_d  = d_i;
        end
        first_d = phase_b && (slot == '0);
        nls_d   = (phase_b || rd_diff) && (slot == '0);
        last_d  = rd_diff && (slot == SLOT_MSK);
        rot_d   = rd_diff;
    end

    // Read-ahead: the slot needed next cycle is fetched now; the bypass covers
    // the single-slot case where that slot is also being written this cycle.
    always_ff @(posedge clk) begin
        if (we) mem[slot] <= wdata;
        rd_q <= mem[rd_addr];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_q      <= 1'b0;
            flush_q    <= 1'b0;
            pend_q     <= 1'b0;
            btb_q      <= 1'b0;
            cnt_q      <= '0;
            byp_q      <= 1'b0;
            byp_data_q <= '0;
            d_real_q   <= '0;
            d_img_q    <= '0;
            first_q    <= 1'b0;
            last_q     <= 1'b0;
            nls_q      <= 1'b0;
            rot_q      <= 1'b0;
        end else begin
            run_q      <= run_d;
            flush_q    <= flush_d;
            pend_q     <= pend_d;
            btb_q      <= btb_d;
            cnt_q      <= cnt_d;
            byp_q      <= we && (slot == rd_addr);
            byp_data_q <= wdata;
            d_real_q   <= d_real_d;
            d_img_q    <= d_img_d;
            first_q    <= first_d;
            last_q     <= last_d;
            nls_q      <= nls_d;
            rot_q      <= rot_d;
        end
    end

    assign D_real           = d_real_q;
    assign D_img            = d_img_q;
    assign data_out_first   = first_q;
    assign data_out_last    = last_q;
    assign next_level_start = nls_q;
    assign rotator_valid    = rot_q;
endmodule

// File: tb/tb_butterfly_general.sv
// Bench for butterfly_general: three instances (layer 3, 12, 1) driven one at a time,
// every output cycle compared against expectations from hand tables or a frame-level model.
module tb_butterfly_general;
    localparam int PMAX = 2147483647;
    localparam int NMIN = 32'sh8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] a_r, a_i;
    logic        st [3];
    logic        en [3];
    logic        nls [3];
    logic        fst [3];
    logic        lst [3];
    logic        rot [3];
    logic [31:0] dr [3];
    logic [31:0] di [3];

    always #5 clk = ~clk;

    butterfly_general #(.layer(3), .WIDTH(32)) u_l3 (
        .clk(clk), .rst(rst), .data_in_start(st[0]), .data_in_end(en[0]),
        .A_real(a_r), .A_img(a_i), .next_level_start(nls[0]), .D_real(dr[0]), .D_img(di[0]),
        .data_out_first(fst[0]), .data_out_last(lst[0]), .rotator_valid(rot[0]));
    butterfly_general #(.layer(12), .WIDTH(32)) u_l12 (
        .clk(clk), .rst(rst), .data_in_start(st[1]), .data_in_end(en[1]),
        .A_real(a_r), .A_img(a_i), .next_level_start(nls[1]), .D_real(dr[1]), .D_img(di[1]),
        .data_out_first(fst[1]), .data_out_last(lst[1]), .rotator_valid(rot[1]));
    butterfly_general #(.layer(1), .WIDTH(32)) u_l1 (
        .clk(clk), .rst(rst), .data_in_start(st[2]), .data_in_end(en[2]),
        .A_real(a_r), .A_img(a_i), .next_level_start(nls[2]), .D_real(dr[2]), .D_img(di[2]),
        .data_out_first(fst[2]), .data_out_last(lst[2]), .rotator_valid(rot[2]));

    typedef struct packed {
        logic [31:0] r;
        logic [31:0] i;
        logic        first;
        logic        last;
        logic        nls;
        logic        rot;
    } exp_t;

    typedef struct {
        int xr[8]; int xi[8];
        int sr[4]; int si[4]; int tr[4]; int ti[4];
    } vec_t;

    vec_t tbl [4];
    exp_t exp0 [int];
    exp_t exp1 [int];
    exp_t exp2 [int];
    int   fr_r [4096];
    int   fr_i [4096];
    int   last_e0 [3];
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    int   rot12 = 0, first12 = -1, last12 = -1;
    bit   spur = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int lay(input int w);
        return (w == 0) ? 3 : (w == 1) ? 12 : 1;
    endfunction

    function automatic void put_exp(input int w, input int c, input exp_t e);
        case (w)
            0: exp0[c] = e;
            1: exp1[c] = e;
            default: exp2[c] = e;
        endcase
    endfunction

    function automatic exp_t take_exp(input int w, input int c);
        exp_t e = '0;
        case (w)
            0: if (exp0.exists(c)) begin e = exp0[c]; exp0.delete(c); end
            1: if (exp1.exists(c)) begin e = exp1[c]; exp1.delete(c); end
            default: if (exp2.exists(c)) begin e = exp2[c]; exp2.delete(c); end
        endcase
        return e;
    endfunction

    task automatic cmp(input string nm, input int w, input exp_t e);
        exp_t g;
        g = '{r: dr[w], i: di[w], first: fst[w], last: lst[w], nls: nls[w], rot: rot[w]};
        vectors++;
        if (g !== e) begin
            miscompares++;
            $display("FAIL %s L%0d cyc=%0d got D=%h/%h f%b l%b n%b r%b want D=%h/%h f%b l%b n%b r%b",
                     nm, lay(w), cyc, g.r, g.i, g.first, g.last, g.nls, g.rot,
                     e.r, e.i, e.first, e.last, e.nls, e.rot);
        end
    endtask

    always @(negedge clk) begin
        for (int w = 0; w < 3; w++) cmp("stream", w, take_exp(w, cyc));
        if (rot[1]) rot12++;
        if (fst[1]) first12 = cyc;
        if (lst[1]) last12 = cyc;
    end

    // Frame-level reference: pair x[k] with x[k+M], halve sum and difference.
    function automatic void push_model(input int w, input int e0, input int n);
        int m = n / 2;
        for (int k = 0; k < m; k++) begin
            longint ar = longint'(fr_r[k]), br = longint'(fr_r[k+m]);
            longint ai = longint'(fr_i[k]), bi = longint'(fr_i[k+m]);
            longint sr = (ar + br) >>> 1, si = (ai + bi) >>> 1;
            longint tr = (ar - br) >>> 1, ti = (ai - bi) >>> 1;
            exp_t e;
            e = '{r: sr[31:0], i: si[31:0], first: (k == 0), last: 1'b0, nls: (k == 0), rot: 1'b0};
            put_exp(w, e0 + m + k, e);
            e = '{r: tr[31:0], i: ti[31:0], first: 1'b0, last: (k == m-1), nls: (k == 0), rot: 1'b1};
            put_exp(w, e0 + n + k, e);
        end
    endfunction

    function automatic void push_table(input int e0, input int t);
        for (int k = 0; k < 4; k++) begin
            exp_t e;
            e = '{r: tbl[t].sr[k], i: tbl[t].si[k], first: (k == 0), last: 1'b0, nls: (k == 0), rot: 1'b0};
            put_exp(0, e0 + 4 + k, e);
            e = '{r: tbl[t].tr[k], i: tbl[t].ti[k], first: 1'b0, last: (k == 3), nls: (k == 0), rot: 1'b1};
            put_exp(0, e0 + 8 + k, e);
        end
    endfunction

    task automatic set_ctl(input int w, input bit s, input bit e);
        for (int i = 0; i < 3; i++) begin
            st[i] = (i == w) && s;
            en[i] = (i == w) && e;
        end
    endtask

    task automatic idle(input int k);
        repeat (k) begin
            @(posedge clk); #1;
            a_r = $urandom; a_i = $urandom;
            set_ctl(-1, 1'b0, 1'b0);
        end
    endtask

    task automatic send_frame(input int w, input int nsend, input int t);
        int n = 1 << lay(w);
        for (int j = 0; j < nsend; j++) begin
            @(posedge clk); #1;
            if (j == 0) begin
                last_e0[w] = cyc + 1;
                if (t >= 0) push_table(cyc + 1, t);
                else push_model(w, cyc + 1, n);
            end
            a_r = fr_r[j]; a_i = fr_i[j];
            set_ctl(w, (j == 0) || (spur && j == 2 && n > 4), (j == n-1) || (spur && j == 2 && n > 4));
        end
    endtask

    task automatic load_tbl(input int t);
        for (int j = 0; j < 8; j++) begin fr_r[j] = tbl[t].xr[j]; fr_i[j] = tbl[t].xi[j]; end
    endtask

    task automatic load_rand(input int n);
        for (int j = 0; j < n; j++) begin
            case ($urandom_range(0, 5))
                0: begin fr_r[j] = PMAX; fr_i[j] = NMIN; end
                1: begin fr_r[j] = NMIN; fr_i[j] = PMAX; end
                default: begin fr_r[j] = int'($urandom); fr_i[j] = int'($urandom); end
            endcase
        end
    endtask

    initial begin
        tbl[0].xr = '{0, 1, 2, 3, 4, 5, 6, 7};   tbl[0].xi = '{0, 0, 0, 0, 0, 0, 0, 0};
        tbl[0].sr = '{2, 3, 4, 5};               tbl[0].si = '{0, 0, 0, 0};
        tbl[0].tr = '{-2, -2, -2, -2};           tbl[0].ti = '{0, 0, 0, 0};
        tbl[1].xr = '{PMAX, PMAX, PMAX, PMAX, PMAX, PMAX, PMAX, PMAX};
        tbl[1].xi = '{NMIN, NMIN, NMIN, NMIN, NMIN, NMIN, NMIN, NMIN};
        tbl[1].sr = '{PMAX, PMAX, PMAX, PMAX};   tbl[1].si = '{NMIN, NMIN, NMIN, NMIN};
        tbl[1].tr = '{0, 0, 0, 0};               tbl[1].ti = '{0, 0, 0, 0};
        tbl[2].xr = '{3, -3, 5, -1, 0, 0, 0, 0}; tbl[2].xi = '{0, 0, 0, 0, 1, 1, 1, -1};
        tbl[2].sr = '{1, -2, 2, -1};             tbl[2].si = '{0, 0, 0, -1};
        tbl[2].tr = '{1, -2, 2, -1};             tbl[2].ti = '{-1, -1, -1, 0};
        tbl[3].xr = '{NMIN, NMIN, NMIN, NMIN, PMAX, PMAX, PMAX, PMAX};
        tbl[3].xi = '{PMAX, PMAX, PMAX, PMAX, NMIN, NMIN, NMIN, NMIN};
        tbl[3].sr = '{-1, -1, -1, -1};           tbl[3].si = '{-1, -1, -1, -1};
        tbl[3].tr = '{NMIN, NMIN, NMIN, NMIN};   tbl[3].ti = '{PMAX, PMAX, PMAX, PMAX};

        rst = 1'b0; a_r = '0; a_i = '0;
        set_ctl(-1, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        idle(5);

        // Table cases, each in isolation, with gaps long enough to finish the flush.
        for (int t = 0; t < 4; t++) begin
            load_tbl(t); send_frame(0, 8, t);
            idle(4 + $urandom_range(0, 3));
        end

        // Back-to-back frames, then a start during flush that must be ignored.
        load_tbl(0); send_frame(0, 8, 0);
        load_tbl(2); send_frame(0, 8, 2);
        idle(1);
        @(posedge clk); #1; set_ctl(0, 1'b1, 1'b0);
        idle(8);

        // Randomized frames, mixing gaps, back-to-back and spurious mid-frame flags.
        for (int r = 0; r < 12; r++) begin
            spur = ($urandom_range(0, 2) == 0);
            load_rand(8); send_frame(0, 8, -1);
            spur = 0;
            if ($urandom_range(0, 1) != 0) idle(4 + $urandom_range(0, 2));
        end
        idle(6);
        for (int r = 0; r < 10; r++) begin
            load_rand(2); send_frame(2, 2, -1);
            if ($urandom_range(0, 1) != 0) idle(1 + $urandom_range(0, 2));
        end
        idle(4);

        // Large frame: latency, diff window length, output span.
        load_rand(4096); send_frame(1, 4096, -1);
        idle(2048 + 4);
        vectors++;
        if (rot12 != 2048) begin miscompares++; $display("FAIL rot_len got %0d want 2048", rot12); end
        vectors++;
        if (first12 - last_e0[1] != 2048) begin
            miscompares++; $display("FAIL first_lat got %0d want 2048", first12 - last_e0[1]);
        end
        vectors++;
        if (last12 - first12 != 4095) begin
            miscompares++; $display("FAIL last_span got %0d want 4095", last12 - first12);
        end

        // Reset while sample 5 of a frame is presented; a sum is already on D.
        load_tbl(0); send_frame(0, 6, -1);
        rst = 1'b0;
        #1;
        cmp("async_rst", 0, '0);
        exp0.delete();
        idle(2);
        rst = 1'b1;
        idle(2);
        load_tbl(3); send_frame(0, 8, 3);
        idle(10);

        vectors++;
        if (exp0.size() + exp1.size() + exp2.size() != 0) begin
            miscompares++;
            $display("FAIL leftover got %0d want 0", exp0.size() + exp1.size() + exp2.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
